// File: rtl/sync_fifo_flags.sv
// Parameterised single-clock FIFO with occupancy count, programmable almost flags,
// standard or first-word-fall-through read, sticky error flags and synchronous flush.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int AF_LEVEL   = 28,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_err
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_r;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  rd_do;
    logic                  wr_do;

    // Explicit wrap so non-power-of-two depths use exactly DEPTH slots.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign count        = count_r;
    assign empty        = (count_r == '0);
    assign full         = (count_r == CW'(DEPTH));
    assign almost_full  = (count_r >= CW'(AF_LEVEL));
    assign almost_empty = (count_r <= CW'(AE_LEVEL));

    assign rd_acc = read_en && !empty;
    assign wr_acc = write_en && (!full || rd_acc);
    // Flush swallows same-cycle requests entirely, including their error side effects.
    assign rd_do  = rd_acc && !flush;
    assign wr_do  = wr_acc && !flush;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (wr_do) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_do) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_do, rd_do})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_do) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (clear_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (write_en && !wr_acc && !flush) overflow  <= 1'b1;
            if (read_en && empty && !flush)    underflow <= 1'b1;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    data_out <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_do;
                    if (rd_do) data_out <= mem[rd_ptr];
                end
            end
        end else begin : g_fwft
            assign rd_valid = !empty;
            assign data_out = empty ? '0 : mem[rd_ptr];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: a standard-mode 32-deep FIFO and a 5-deep FWFT FIFO side by side.
module tb_sync_fifo_flags;

    logic       clock = 1'b0;
    logic       reset_n;
    always #5 clock = ~clock;

    // standard-mode instance
    logic       flush, write_en, read_en, clear_err;
    logic [7:0] data_in;
    logic       full, almost_full, empty, almost_empty, rd_valid, overflow, underflow;
    logic [7:0] data_out;
    logic [5:0] count;

    // FWFT instance
    logic       f_flush, f_write_en, f_read_en, f_clear_err;
    logic [7:0] f_data_in;
    logic       f_full, f_almost_full, f_empty, f_almost_empty, f_rd_valid, f_overflow, f_underflow;
    logic [7:0] f_data_out;
    logic [2:0] f_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] f_exp_q[$];

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(0)) u_std (
        .clock(clock), .reset_n(reset_n), .flush(flush), .data_in(data_in),
        .write_en(write_en), .full(full), .almost_full(almost_full), .read_en(read_en),
        .data_out(data_out), .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .clear_err(clear_err)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_fwft (
        .clock(clock), .reset_n(reset_n), .flush(f_flush), .data_in(f_data_in),
        .write_en(f_write_en), .full(f_full), .almost_full(f_almost_full), .read_en(f_read_en),
        .data_out(f_data_out), .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_almost_empty),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow), .clear_err(f_clear_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Standard mode: every valid output word must match the next queued expectation.
    always @(negedge clock) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL std_unexpected_valid: got data 0x%0h expected no output", data_out);
            end else begin
                chk("std_data", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    // FWFT: the head word is checked when it is consumed.
    always @(negedge clock) begin
        if (f_read_en && f_rd_valid) begin
            if (f_exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL fwft_unexpected_pop: got data 0x%0h expected no output", f_data_out);
            end else begin
                chk("fwft_data", int'(f_data_out), int'(f_exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        flush = 0; write_en = 0; read_en = 0; clear_err = 0; data_in = 8'h00;
        f_flush = 0; f_write_en = 0; f_read_en = 0; f_clear_err = 0; f_data_in = 8'h00;
        step(); step();
        reset_n = 1'b1;
        step();

        // 1: reset defaults
        chk("rst_empty", empty, 1);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_overflow", overflow, 0);

        // 2: fill 0x01..0x20 then drain in order
        for (int i = 1; i <= 32; i++) begin
            data_in = 8'(i); write_en = 1; step();
            chk("fill_count", count, i);
            chk("fill_almost_full", almost_full, (i >= 28) ? 1 : 0);
            chk("fill_full", full, (i == 32) ? 1 : 0);
        end
        write_en = 0;
        for (int i = 1; i <= 32; i++) begin
            read_en = 1; exp_q.push_back(8'(i)); step();
            chk("drain_rd_valid", rd_valid, 1);
            chk("drain_almost_empty", almost_empty, ((32 - i) <= 4) ? 1 : 0);
        end
        read_en = 0; step();
        chk("drain_empty", empty, 1);
        chk("drain_rd_valid_idle", rd_valid, 0);

        // 3: simultaneous read/write while full, then overflow and clear
        for (int i = 0; i < 32; i++) begin
            data_in = 8'(8'h40 + i); write_en = 1; step();
        end
        chk("full3_full", full, 1);
        data_in = 8'hAA; write_en = 1; read_en = 1; exp_q.push_back(8'h40); step();
        chk("rw_full_count", count, 32);
        chk("rw_full_overflow", overflow, 0);
        data_in = 8'hBB; write_en = 1; read_en = 0; step();
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 32);
        write_en = 0; clear_err = 1; step();
        clear_err = 0;
        chk("ovf_cleared", overflow, 0);
        for (int i = 1; i < 32; i++) exp_q.push_back(8'(8'h40 + i));
        exp_q.push_back(8'hAA);
        read_en = 1;
        for (int i = 0; i < 32; i++) step();
        read_en = 0; step();
        chk("rw_drained_empty", empty, 1);

        // 4: underflow, then write while read_en held on empty
        read_en = 1; step();
        chk("udf_set", underflow, 1);
        chk("udf_rd_valid", rd_valid, 0);
        data_in = 8'h5A; write_en = 1; step();
        chk("udf_write_count", count, 1);
        chk("udf_write_no_valid", rd_valid, 0);
        write_en = 0; exp_q.push_back(8'h5A); step();
        chk("udf_read_valid", rd_valid, 1);
        read_en = 0; clear_err = 1; step();
        clear_err = 0;
        chk("udf_cleared", underflow, 0);

        // 6: flush with a concurrent write
        for (int i = 0; i < 10; i++) begin
            data_in = 8'(8'h60 + i); write_en = 1; step();
        end
        chk("pre_flush_count", count, 10);
        flush = 1; data_in = 8'h77; write_en = 1; step();
        flush = 0; write_en = 0;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_overflow", overflow, 0);
        data_in = 8'h99; write_en = 1; step();
        write_en = 0; read_en = 1; exp_q.push_back(8'h99); step();
        read_en = 0; step();
        chk("post_flush_empty", empty, 1);

        // 5: FWFT, depth 5, pointer wrap
        f_data_in = 8'h11; f_write_en = 1; f_exp_q.push_back(8'h11); step();
        f_write_en = 0;
        chk("fwft_empty", f_empty, 0);
        chk("fwft_head", f_data_out, 8'h11);
        chk("fwft_valid", f_rd_valid, 1);
        for (int i = 2; i <= 5; i++) begin
            f_data_in = 8'(8'h11 * i); f_write_en = 1; f_exp_q.push_back(8'(8'h11 * i)); step();
        end
        f_write_en = 0;
        chk("fwft_full", f_full, 1);
        chk("fwft_count", f_count, 5);
        f_read_en = 1;
        for (int i = 0; i < 5; i++) step();
        f_read_en = 0;
        chk("fwft_drained", f_empty, 1);
        chk("fwft_no_underflow", f_underflow, 0);
        f_data_in = 8'h66; f_write_en = 1; f_exp_q.push_back(8'h66); step();
        f_data_in = 8'h77; f_exp_q.push_back(8'h77); step();
        f_write_en = 0;
        chk("fwft_wrap_head", f_data_out, 8'h66);
        f_read_en = 1; step(); step();
        f_read_en = 0;
        chk("fwft_wrap_empty", f_empty, 1);

        step();
        chk("std_queue_drained", exp_q.size(), 0);
        chk("fwft_queue_drained", f_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
